// File: rtl/itrace_ringbuf.sv
// itrace_ringbuf: keeps the last DEPTH retired {pc,inst} pairs and drains them oldest-first on request.
// Optional ITRACE_AUTO_TRIG_EN: an ebreak or illegal retirement starts the drain without dump_req.
module itrace_ringbuf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit_valid,
  input  logic [31:0]   commit_pc,
  input  logic [31:0]   commit_inst,
  input  logic          commit_illegal,
  input  logic          dump_req,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [31:0]   dump_pc,
  output logic [31:0]   dump_inst,
  output logic [AW-1:0] dump_idx,
  output logic          dump_last,
  output logic          busy,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          dropped
);
  localparam int CW = AW + 1;
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);
  localparam logic [AW:0]   CNT_ONE_C = CW'(1);
  localparam logic [AW:0]   CNT_TWO_C = CW'(2);

  typedef enum logic [0:0] {CAPTURE = 1'b0, DUMP = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, idx_r;
  logic [AW:0]   count_r, remain_r;
  logic          overflow_r, dropped_r, dump_valid_r, dump_last_r;
  logic [31:0]   dump_pc_r, dump_inst_r;

  logic          trig_s, wr_en_s, start_s, beat_s, finish_s;
  logic [AW-1:0] wr_ptr_post_s, rd_start_s, rd_nxt_s;
  logic [AW:0]   count_post_s;
  logic [63:0]   start_data_s;

  logic          valid_nxt_s, last_nxt_s;
  logic [63:0]   data_nxt_s;
  logic [AW-1:0] idx_nxt_s, rd_ptr_nxt_s;
  logic [AW:0]   remain_nxt_s;

`ifdef ITRACE_AUTO_TRIG_EN
  localparam logic [31:0] EBREAK_C = 32'h0010_0073;
  assign trig_s = dump_req | (commit_valid & ((commit_inst == EBREAK_C) | commit_illegal));
`else
  logic unused_illegal_s;
  assign unused_illegal_s = commit_illegal;
  assign trig_s = dump_req;
`endif

  // Capture-side pointer/count arithmetic and drain handshake decode.
  always_comb begin
    wr_en_s = (state_r == CAPTURE) & commit_valid;
    if (wr_en_s) begin
      wr_ptr_post_s = wr_ptr_r + PTR_ONE_C;
      count_post_s  = (count_r == DEPTH_C) ? DEPTH_C : count_r + CNT_ONE_C;
    end else begin
      wr_ptr_post_s = wr_ptr_r;
      count_post_s  = count_r;
    end
    // With a full buffer the low count bits are zero, so the oldest entry is the write pointer.
    rd_start_s = wr_ptr_post_s - count_post_s[AW-1:0];
    start_s    = (state_r == CAPTURE) & trig_s & (count_post_s != {CW{1'b0}});
    beat_s     = dump_valid_r & dump_ready;
    finish_s   = beat_s & dump_last_r;
    rd_nxt_s   = rd_ptr_r + PTR_ONE_C;
    // A lone same-cycle commit is the first beat but is not yet in the array.
    if (wr_en_s && (rd_start_s == wr_ptr_r)) begin
      start_data_s = {commit_pc, commit_inst};
    end else begin
      start_data_s = mem_r[rd_start_s];
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_r)
      CAPTURE: state_nxt_s = start_s ? DUMP : CAPTURE;
      DUMP:    state_nxt_s = finish_s ? CAPTURE : DUMP;
      default: state_nxt_s = CAPTURE;
    endcase
  end

  // Next values of the registered dump port and read cursor.
  always_comb begin
    valid_nxt_s  = dump_valid_r;
    last_nxt_s   = dump_last_r;
    data_nxt_s   = {dump_pc_r, dump_inst_r};
    idx_nxt_s    = idx_r;
    rd_ptr_nxt_s = rd_ptr_r;
    remain_nxt_s = remain_r;
    case (state_r)
      CAPTURE: begin
        if (start_s) begin
          valid_nxt_s  = 1'b1;
          last_nxt_s   = (count_post_s == CNT_ONE_C);
          data_nxt_s   = start_data_s;
          idx_nxt_s    = {AW{1'b0}};
          rd_ptr_nxt_s = rd_start_s;
          remain_nxt_s = count_post_s;
        end else begin
          valid_nxt_s  = 1'b0;
          last_nxt_s   = 1'b0;
        end
      end
      DUMP: begin
        if (finish_s) begin
          valid_nxt_s  = 1'b0;
          last_nxt_s   = 1'b0;
          remain_nxt_s = {CW{1'b0}};
        end else if (beat_s) begin
          last_nxt_s   = (remain_r == CNT_TWO_C);
          data_nxt_s   = mem_r[rd_nxt_s];
          idx_nxt_s    = idx_r + PTR_ONE_C;
          rd_ptr_nxt_s = rd_nxt_s;
          remain_nxt_s = remain_r - CNT_ONE_C;
        end else begin
          valid_nxt_s  = dump_valid_r;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pointer, sticky-flag and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= CAPTURE;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      idx_r        <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      remain_r     <= {CW{1'b0}};
      overflow_r   <= 1'b0;
      dropped_r    <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_last_r  <= 1'b0;
      dump_pc_r    <= 32'h0000_0000;
      dump_inst_r  <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      wr_ptr_r     <= wr_ptr_post_s;
      count_r      <= finish_s ? {CW{1'b0}} : count_post_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      idx_r        <= idx_nxt_s;
      remain_r     <= remain_nxt_s;
      dump_valid_r <= valid_nxt_s;
      dump_last_r  <= last_nxt_s;
      dump_pc_r    <= data_nxt_s[63:32];
      dump_inst_r  <= data_nxt_s[31:0];
      if (wr_en_s && (count_r == DEPTH_C)) begin
        overflow_r <= 1'b1;
      end else if (finish_s) begin
        overflow_r <= 1'b0;
      end
      if ((state_r == DUMP) && commit_valid) begin
        dropped_r <= 1'b1;
      end
    end
  end

  // Trace storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {commit_pc, commit_inst};
    end
  end

  assign dump_valid = dump_valid_r;
  assign dump_last  = dump_last_r;
  assign dump_pc    = dump_pc_r;
  assign dump_inst  = dump_inst_r;
  assign dump_idx   = idx_r;
  assign busy       = (state_r == DUMP);
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign dropped    = dropped_r;
endmodule

// File: tb/tb_itrace_ringbuf.sv
// Directed bench for itrace_ringbuf: per-cycle vector table plus hand-written reset sequences.
module tb_itrace_ringbuf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid = 1'b0, commit_illegal = 1'b0, dump_req = 1'b0, dump_ready = 1'b0;
  logic [31:0] commit_pc = 32'h0, commit_inst = 32'h0;
  logic        dump_valid, dump_last, busy, overflow, dropped;
  logic [31:0] dump_pc, dump_inst;
  logic [3:0]  dump_idx;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic        cv;
    logic [31:0] cpc;
    logic [31:0] cinst;
    logic        cill;
    logic        req;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [3:0]  eidx;
    logic        el;
    logic        eb;
    logic [4:0]  ec;
    logic        eo;
    logic        ed;
  } vec_t;

  vec_t tbl[$];

  itrace_ringbuf #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_illegal(commit_illegal), .dump_req(dump_req),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_pc(dump_pc), .dump_inst(dump_inst),
    .dump_idx(dump_idx), .dump_last(dump_last), .busy(busy), .count(count),
    .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc + 32'h0000_0013;
  endfunction

  task automatic push(input string nm, input logic cv, input logic [31:0] cpc, input logic [31:0] cinst,
                      input logic cill, input logic req, input logic rdy, input logic ev,
                      input logic [31:0] epc, input logic [31:0] einst, input int eidx, input logic el,
                      input logic eb, input int ec, input logic eo, input logic ed);
    vec_t v;
    v.nm = nm; v.cv = cv; v.cpc = cpc; v.cinst = cinst; v.cill = cill; v.req = req; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einst = einst; v.eidx = eidx[3:0]; v.el = el; v.eb = eb;
    v.ec = ec[4:0]; v.eo = eo; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      logic ok;
      @(negedge clk);
      commit_valid = tbl[i].cv; commit_pc = tbl[i].cpc; commit_inst = tbl[i].cinst;
      commit_illegal = tbl[i].cill; dump_req = tbl[i].req; dump_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      total++;
      ok = (dump_valid === tbl[i].ev) && (busy === tbl[i].eb) && (count === tbl[i].ec) &&
           (overflow === tbl[i].eo) && (dropped === tbl[i].ed) && (dump_last === tbl[i].el);
      if (tbl[i].ev) begin
        ok = ok && (dump_pc === tbl[i].epc) && (dump_inst === tbl[i].einst) && (dump_idx === tbl[i].eidx);
      end
      if (!ok) begin
        bad++;
        $display("FAIL %s[%0d]: got v=%b pc=%h inst=%h idx=%0d last=%b busy=%b cnt=%0d ovf=%b drp=%b want v=%b pc=%h inst=%h idx=%0d last=%b busy=%b cnt=%0d ovf=%b drp=%b",
                 tbl[i].nm, i, dump_valid, dump_pc, dump_inst, dump_idx, dump_last, busy, count, overflow, dropped,
                 tbl[i].ev, tbl[i].epc, tbl[i].einst, tbl[i].eidx, tbl[i].el, tbl[i].eb, tbl[i].ec, tbl[i].eo, tbl[i].ed);
      end
    end
    tbl.delete();
    @(negedge clk);
    commit_valid = 1'b0; commit_illegal = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] b;
    #2;
    chk("reset_outputs", {dump_valid, dump_last, busy, overflow, dropped, dump_idx, count, 18'h0},
        64'h0);
    chk("reset_data", {dump_pc, dump_inst}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // test 1: five commits then a drain with ready held high
    b = 32'h8000_0000;
    for (int k = 0; k < 5; k++)
      push("t1_commit", 1'b1, b + 4*k, ins(b + 4*k), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, k + 1, 1'b0, 1'b0);
    push("t1_req", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, b, ins(b), 0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    for (int j = 1; j < 5; j++)
      push("t1_beat", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, b + 4*j, ins(b + 4*j), j, j == 4, 1'b1, 5, 1'b0, 1'b0);
    push("t1_end", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // test 3: same five entries, ready toggling so each beat is held one extra cycle
    for (int k = 0; k < 5; k++)
      push("t3_commit", 1'b1, b + 4*k, ins(b + 4*k), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, k + 1, 1'b0, 1'b0);
    push("t3_req", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, b, ins(b), 0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    for (int s = 1; s < 9; s++)
      push("t3_toggle", 1'b0, 0, 0, 1'b0, 1'b0, s % 2 == 1, 1'b1, b + 4*((s + 1) / 2), ins(b + 4*((s + 1) / 2)),
           (s + 1) / 2, (s + 1) / 2 == 4, 1'b1, 5, 1'b0, 1'b0);
    push("t3_end", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // test 2: twenty commits into sixteen slots, overflow and pointer wrap
    for (int k = 0; k < 20; k++)
      push("t2_commit", 1'b1, 4*k, ins(4*k), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0,
           (k + 1 > 16) ? 16 : k + 1, k >= 16, 1'b0);
    push("t2_req", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, ins(32'h10), 0, 1'b0, 1'b1, 16, 1'b1, 1'b0);
    for (int j = 1; j < 16; j++)
      push("t2_beat", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10 + 4*j, ins(32'h10 + 4*j), j, j == 15, 1'b1, 16, 1'b1, 1'b0);
    push("t2_end", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // test 4: same-cycle commit joins the dump; commit and dump_req during DUMP
    push("t4_commit", 1'b1, 32'h200, ins(32'h200), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    push("t4_commit", 1'b1, 32'h204, ins(32'h204), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    push("t4_req_commit", 1'b1, 32'h100, ins(32'h100), 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, ins(32'h200), 0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    push("t4_drop", 1'b1, 32'h999, ins(32'h999), 1'b0, 1'b1, 1'b1, 1'b1, 32'h204, ins(32'h204), 1, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    push("t4_last", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, ins(32'h100), 2, 1'b1, 1'b1, 3, 1'b0, 1'b1);
    push("t4_end", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_table();

    // test 5: reset in the middle of a drain, then dump_req on an empty buffer
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      commit_valid = 1'b1; commit_pc = 32'h4000 + 4*k; commit_inst = ins(32'h4000 + 4*k);
    end
    @(negedge clk);
    commit_valid = 1'b0; dump_req = 1'b1; dump_ready = 1'b1;
    @(posedge clk);
    #1 dump_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t5_mid", {27'h0, dump_valid, busy, dump_idx, dump_pc}, {27'h0, 1'b1, 1'b1, 4'd2, 32'h4008});
    dump_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst", {dump_valid, dump_last, busy, overflow, dropped, dump_idx, count, dump_pc, 19'h0}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    dump_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("t5_empty_req", {59'h0, dump_valid, busy, count[2:0]}, 64'h0);
    end
    @(negedge clk);
    dump_req = 1'b0;

    // test 6: ebreak and illegal retirements without dump_req
    push("t6_commit", 1'b1, 32'h0, ins(32'h0), 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    push("t6_commit", 1'b1, 32'h4, ins(32'h4), 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
`ifdef ITRACE_AUTO_TRIG_EN
    push("t6_ebreak", 1'b1, 32'h8, 32'h0010_0073, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, ins(32'h0), 0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    push("t6_beat", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4, ins(32'h4), 1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    push("t6_last", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0010_0073, 2, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    push("t6_end", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
`else
    push("t6_ebreak", 1'b1, 32'h8, 32'h0010_0073, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    push("t6_illegal", 1'b1, 32'hC, ins(32'hC), 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    push("t6_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    push("t6_idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0);
`endif
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
